// File: rtl/disparo_jugador.sv
// Player shot controller: cursor movement, PC-board cell read, confirmed write-back, hit count, victory.
// Optional aiming time limit enabled by defining TURN_TIMEOUT_EN.
module disparo_jugador #(
  parameter int N              = 5,
  parameter int BARCOS_TOTAL   = 5,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  turno,
  input  logic                                  btn_arriba,
  input  logic                                  btn_abajo,
  input  logic                                  btn_izq,
  input  logic                                  btn_der,
  input  logic                                  btn_confirmar,
  input  logic [1:0]                            rd_data,
  output logic [2:0]                            rd_fila,
  output logic [2:0]                            rd_col,
  output logic [2:0]                            cursor_fila,
  output logic [2:0]                            cursor_col,
  output logic                                  wr_en,
  output logic [2:0]                            wr_fila,
  output logic [2:0]                            wr_col,
  output logic [1:0]                            wr_data,
  output logic                                  impacto,
  output logic                                  fallo,
  output logic                                  turno_fin,
  output logic [$clog2(BARCOS_TOTAL+1)-1:0]     aciertos,
  output logic                                  victoria
);

  localparam int CW = 3;
  localparam int AW = $clog2(BARCOS_TOTAL + 1);
  localparam logic [CW-1:0] MAX_POS = CW'(N - 1);
  localparam logic [AW-1:0] TOTAL   = AW'(BARCOS_TOTAL);
  localparam logic [1:0] CASILLA_CONFIRMADA = 2'b11;
  localparam logic [1:0] BARCO              = 2'b01;

  typedef enum logic [2:0] {
    IDLE, APUNTAR, LEER, ESCRIBIR, FIN, GANADO
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] fila_q, fila_d, col_q, col_d;
  logic [AW-1:0] aciertos_q, aciertos_d;
  logic          hit_q, hit_d;
  logic [4:0]    btn_prev_q, btn_prev_d;
  logic [4:0]    btn_now, press;
  logic          timeout;

  // Bit order: 0 arriba, 1 abajo, 2 izq, 3 der, 4 confirmar
  assign btn_now = {btn_confirmar, btn_der, btn_izq, btn_abajo, btn_arriba};
  assign press   = btn_now & ~btn_prev_q;

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic [TW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == APUNTAR) && (cnt_q == TW'(TIMEOUT_CICLOS - 1));

  // Cleared outside APUNTAR, so every entry (including a bounce back from LEER) restarts it
  always_comb begin
    cnt_d = '0;
    if (state_q == APUNTAR && press == '0 && !timeout) cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  // No aiming limit in this build; the comparison is constant-false for legal values
  assign timeout = (TIMEOUT_CICLOS < 0);
`endif

  always_comb begin
    state_d    = state_q;
    fila_d     = fila_q;
    col_d      = col_q;
    aciertos_d = aciertos_q;
    hit_d      = hit_q;
    btn_prev_d = btn_now;
    case (state_q)
      IDLE: if (turno) state_d = APUNTAR;
      APUNTAR: begin
        if (!turno) begin
          state_d = IDLE;
        end else if (press[4] || timeout) begin
          state_d = LEER;
        end else if (press[0]) begin
          fila_d = (fila_q == '0) ? MAX_POS : fila_q - CW'(1);
        end else if (press[1]) begin
          fila_d = (fila_q == MAX_POS) ? '0 : fila_q + CW'(1);
        end else if (press[2]) begin
          col_d = (col_q == '0) ? MAX_POS : col_q - CW'(1);
        end else if (press[3]) begin
          col_d = (col_q == MAX_POS) ? '0 : col_q + CW'(1);
        end
      end
      LEER: begin
        if (rd_data == CASILLA_CONFIRMADA) begin
          state_d = APUNTAR;
        end else begin
          hit_d   = (rd_data == BARCO);
          state_d = ESCRIBIR;
        end
      end
      ESCRIBIR: begin
        if (hit_q && aciertos_q != TOTAL) aciertos_d = aciertos_q + AW'(1);
        state_d = FIN;
      end
      FIN:     state_d = (aciertos_q == TOTAL) ? GANADO : IDLE;
      GANADO:  state_d = GANADO;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fila_q     <= '0;
      col_q      <= '0;
      aciertos_q <= '0;
      hit_q      <= 1'b0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      fila_q     <= fila_d;
      col_q      <= col_d;
      aciertos_q <= aciertos_d;
      hit_q      <= hit_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign rd_fila     = fila_q;
  assign rd_col      = col_q;
  assign cursor_fila = fila_q;
  assign cursor_col  = col_q;
  assign wr_en       = (state_q == ESCRIBIR);
  assign wr_fila     = wr_en ? fila_q : '0;
  assign wr_col      = wr_en ? col_q : '0;
  assign wr_data     = wr_en ? CASILLA_CONFIRMADA : '0;
  assign impacto     = wr_en & hit_q;
  assign fallo       = wr_en & ~hit_q;
  assign turno_fin   = (state_q == FIN);
  assign aciertos    = aciertos_q;
  assign victoria    = (state_q == GANADO);

endmodule

// File: tb/tb_disparo_jugador.sv
// Directed bench for disparo_jugador: board model, turn-level reference model and literal checkpoints.
module tb_disparo_jugador;

  localparam int N = 5;
  localparam int SHIPS = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       turno = 1'b0;
  logic [4:0] btn = '0;   // 0 arriba, 1 abajo, 2 izq, 3 der, 4 confirmar
  logic [1:0] rd_data;
  logic [2:0] rd_fila, rd_col, cursor_fila, cursor_col, wr_fila, wr_col;
  logic       wr_en, impacto, fallo, turno_fin, victoria;
  logic [1:0] wr_data;
  logic [2:0] aciertos;

  int nvec = 0;
  int nfail = 0;

  disparo_jugador #(.N(N), .BARCOS_TOTAL(SHIPS), .TIMEOUT_CICLOS(1000)) dut (
    .clk(clk), .rst(rst), .turno(turno),
    .btn_arriba(btn[0]), .btn_abajo(btn[1]), .btn_izq(btn[2]), .btn_der(btn[3]),
    .btn_confirmar(btn[4]), .rd_data(rd_data),
    .rd_fila(rd_fila), .rd_col(rd_col), .cursor_fila(cursor_fila), .cursor_col(cursor_col),
    .wr_en(wr_en), .wr_fila(wr_fila), .wr_col(wr_col), .wr_data(wr_data),
    .impacto(impacto), .fallo(fallo), .turno_fin(turno_fin),
    .aciertos(aciertos), .victoria(victoria)
  );

  always #5 clk = ~clk;

  // PC board store: combinational read, write captured on the strobe
  logic [1:0] board [0:7][0:7];
  assign rd_data = board[rd_fila][rd_col];
  always @(posedge clk) if (wr_en) board[wr_fila][wr_col] <= wr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks where the player is in a turn and what each pulse must be
  // mode: 0 waiting for turn, 1 aiming, 2 reading target, 3 writing, 4 turn end, 5 won
  int         m_mode = 0, m_r = 0, m_c = 0, m_hits = 0;
  bit         m_hit = 0, m_valid = 0;
  logic [4:0] m_prev = '0, m_pr;

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_r = 0; m_c = 0; m_hits = 0; m_hit = 0; m_prev = '0; m_valid = 1;
    end else begin
      m_pr = btn & ~m_prev;
      m_prev = btn;
      case (m_mode)
        0: if (turno) m_mode = 1;
        1: if (!turno) m_mode = 0;
           else if (m_pr[4]) m_mode = 2;
           else if (m_pr[0]) m_r = (m_r + N - 1) % N;
           else if (m_pr[1]) m_r = (m_r + 1) % N;
           else if (m_pr[2]) m_c = (m_c + N - 1) % N;
           else if (m_pr[3]) m_c = (m_c + 1) % N;
        2: if (board[m_r][m_c] == 2'b11) m_mode = 1;
           else begin m_hit = (board[m_r][m_c] == 2'b01); m_mode = 3; end
        3: begin if (m_hit && m_hits < SHIPS) m_hits++; m_mode = 4; end
        4: m_mode = (m_hits == SHIPS) ? 5 : 0;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cursor", {26'd0, cursor_fila, cursor_col}, 32'(m_r * 8 + m_c));
      chk("rd_addr", {26'd0, rd_fila, rd_col}, 32'(m_r * 8 + m_c));
      chk("write", {23'd0, wr_en, wr_fila, wr_col, wr_data},
          (m_mode == 3) ? 32'(256 + m_r * 32 + m_c * 4 + 3) : 32'd0);
      chk("pulses", {29'd0, impacto, fallo, turno_fin},
          {29'd0, m_mode == 3 && m_hit, m_mode == 3 && !m_hit, m_mode == 4});
      chk("aciertos", {29'd0, aciertos}, 32'(m_hits));
      chk("victoria", {31'd0, victoria}, {31'd0, m_mode == 5});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    step();
    btn[idx] = 1'b0;
    step();
  endtask

  task automatic goto_cell(input int r, input int c);
    for (int k = 0; k < 16 && m_r != r; k++) press(0);
    for (int k = 0; k < 16 && m_c != c; k++) press(3);
    chk("goto", {26'd0, cursor_fila, cursor_col}, 32'(r * 8 + c));
  endtask

  // Leaves the bench in the write cycle of the shot
  task automatic confirm();
    btn[4] = 1'b1;
    step();
    btn[4] = 1'b0;
    step();
  endtask

  task automatic end_turn(input int hits_exp);
    step();
    chk("turno_fin_lit", {31'd0, turno_fin}, 32'd1);
    chk("aciertos_lit", {29'd0, aciertos}, 32'(hits_exp));
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) board[r][c] = 2'b00;
    board[2][3] = 2'b01; board[3][3] = 2'b01; board[4][4] = 2'b01;
    board[1][1] = 2'b01; board[0][0] = 2'b01;

    step(); step(); step();
    chk("rst_cursor", {26'd0, cursor_fila, cursor_col}, 32'd0);
    chk("rst_outs", {25'd0, wr_en, impacto, fallo, turno_fin, victoria, wr_data}, 32'd0);
    chk("rst_aciertos", {29'd0, aciertos}, 32'd0);
    rst = 1'b1;
    turno = 1'b1;
    step();

    // Column wrap 0,1,2,3,4,0,1 then row wrap from 0 up to 4
    for (int i = 0; i < 6; i++) begin
      press(3);
      chk("col_wrap", {29'd0, cursor_col}, 32'((i + 1) % 5));
    end
    press(0);
    chk("row_wrap", {29'd0, cursor_fila}, 32'd4);

    // Hit at (2,3)
    goto_cell(2, 3);
    confirm();
    chk("hit_write", {23'd0, wr_en, wr_fila, wr_col, wr_data}, {23'd0, 1'b1, 3'd2, 3'd3, 2'b11});
    chk("hit_pulses", {30'd0, impacto, fallo}, 32'd2);
    end_turn(1);

    // Miss at (2,4)
    goto_cell(2, 4);
    confirm();
    chk("miss_pulses", {30'd0, impacto, fallo}, 32'd1);
    end_turn(1);

    // Already-confirmed cell: no write, back to aiming, next move accepted
    goto_cell(2, 3);
    btn[4] = 1'b1;
    step();
    btn[4] = 1'b0;
    step();
    chk("reshot_nowrite", {29'd0, wr_en, impacto, fallo}, 32'd0);
    press(1);
    chk("reshot_move", {29'd0, cursor_fila}, 32'd3);

    // arriba+der+confirmar together: shot at unchanged cursor (3,3)
    btn = 5'b11001;
    step();
    btn = '0;
    step();
    chk("simul_cursor", {26'd0, cursor_fila, cursor_col}, 32'(3 * 8 + 3));
    chk("simul_write", {23'd0, wr_en, wr_fila, wr_col, wr_data}, {23'd0, 1'b1, 3'd3, 3'd3, 2'b11});
    chk("simul_hit", {31'd0, impacto}, 32'd1);
    end_turn(2);

    goto_cell(4, 4); confirm(); end_turn(3);
    goto_cell(1, 1); confirm(); end_turn(4);
    goto_cell(0, 0); confirm();
    chk("last_hit", {31'd0, impacto}, 32'd1);
    step();
    chk("fin5", {31'd0, turno_fin}, 32'd1);
    chk("aciertos5", {29'd0, aciertos}, 32'd5);
    step();
    chk("victoria_set", {31'd0, victoria}, 32'd1);

    // Terminal state ignores turno and buttons
    turno = 1'b0; step();
    turno = 1'b1; step();
    press(4);
    press(3);
    chk("won_hold", {28'd0, victoria, wr_en, turno_fin, impacto}, 32'd8);
    chk("won_cursor", {26'd0, cursor_fila, cursor_col}, 32'd0);

    rst = 1'b0;
    step();
    chk("rst_victoria", {31'd0, victoria}, 32'd0);
    chk("rst_aciertos2", {29'd0, aciertos}, 32'd0);
    rst = 1'b1;
    turno = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
